// File: rtl/dac_spi_pkg.sv
// Shared constants for the DAC SPI monitor: frame layout, command/address codes, FSM states.
package dac_spi_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CMD_LSB    = 20;
  localparam int unsigned ADDR_LSB   = 16;
  localparam int unsigned DATA_LSB   = 4;

  localparam logic [3:0] CMD_WR         = 4'h0;
  localparam logic [3:0] CMD_UPD        = 4'h1;
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;

  localparam logic [3:0] ADDR_A   = 4'h0;
  localparam logic [3:0] ADDR_B   = 4'h1;
  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Only the write-and-update commands move the DAC output, so only they touch the shadows.
  function automatic logic updates_shadow(input logic [3:0] c);
    return (c == CMD_WR_UPD) || (c == CMD_WR_UPD_ALL);
  endfunction

endpackage

// File: rtl/dac_spi_monitor_if.sv
// DAC SPI bus as driven by the DAC driver; the monitor only ever listens.
interface dac_spi_monitor_if;
  logic SPI_SCK;
  logic SPI_MOSI;
  logic DAC_CS;
  logic DAC_CLR;

  modport master (output SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR);
  modport slave  (input  SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR);
endinterface

// File: rtl/dac_spi_monitor_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle rise/fall strobes.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/dac_spi_monitor.sv
// Passive DAC SPI frame decoder: rebuilds 32-bit frames, reports fields, keeps A/B code shadows.
module dac_spi_monitor
  import dac_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 12
) (
  input  logic              qzt_clk,
  input  logic              rst_n,
  dac_spi_monitor_if.slave  spi,
  output logic              frame_valid,
  output logic              frame_error,
  output logic [3:0]        cmd,
  output logic [3:0]        addr,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] dac_a,
  output logic [DATA_W-1:0] dac_b,
  output logic              busy
);

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic clr_s, clr_rise, clr_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_chain;

  // CS synchroniser resets low so a reset mid-transfer lands in RESYNC and waits out the tail.
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(qzt_clk), .rst_n(rst_n), .d(spi.SPI_SCK), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(qzt_clk), .rst_n(rst_n), .d(spi.DAC_CS), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (
    .clk(qzt_clk), .rst_n(rst_n), .d(spi.DAC_CLR), .q(clr_s), .rise(clr_rise), .fall(clr_fall)
  );

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) mosi_chain <= '0;
    else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi.SPI_MOSI};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  state_t                  state, state_n;
  logic [FRAME_BITS-1:0]   sr;
  logic [5:0]              bit_cnt;
  logic                    done_good, done_bad;

  logic [3:0]        cmd_f, addr_f;
  logic [DATA_W-1:0] data_f;
  assign cmd_f  = sr[CMD_LSB +: 4];
  assign addr_f = sr[ADDR_LSB +: 4];
  assign data_f = sr[DATA_LSB +: DATA_W];

  logic unused_bits;
  assign unused_bits = &{sck_s, sck_fall, clr_rise, clr_fall, sr[31:24], sr[3:0]};

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESYNC;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    done_good = 1'b0;
    done_bad  = 1'b0;
    busy      = (state == ST_SHIFT);
    if (!clr_s) begin
      state_n = ST_RESYNC;
    end else begin
      case (state)
        ST_RESYNC: if (cs_s)    state_n = ST_IDLE;
        ST_IDLE:   if (cs_fall) state_n = ST_SHIFT;
        ST_SHIFT:  if (cs_rise) state_n = ST_DONE;
        ST_DONE: begin
          state_n = ST_IDLE;
          if (bit_cnt == CNT_FULL) done_good = 1'b1;
          else                     done_bad  = 1'b1;
        end
        default: state_n = ST_RESYNC;
      endcase
    end
  end

  // Pulses and fields are registered out of DONE, giving the two-cycle latency from the CS rise.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      cmd         <= '0;
      addr        <= '0;
      data        <= '0;
      dac_a       <= '0;
      dac_b       <= '0;
    end else begin
      frame_valid <= done_good;
      frame_error <= done_bad;
      if (state == ST_IDLE && cs_fall) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (state == ST_SHIFT && sck_rise && !cs_s) begin
        sr <= {sr[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
      end
      if (done_good) begin
        cmd  <= cmd_f;
        addr <= addr_f;
        data <= data_f;
        if (updates_shadow(cmd_f)) begin
          if (addr_f == ADDR_A || addr_f == ADDR_ALL) dac_a <= data_f;
          if (addr_f == ADDR_B || addr_f == ADDR_ALL) dac_b <= data_f;
        end
      end
      if (!clr_s) begin
        dac_a <= '0;
        dac_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_monitor.sv
// Directed bench for dac_spi_monitor: good, short/long, reset-aborted and clear-aborted frames.
module tb_dac_spi_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fv, fe, busy;
  logic [3:0]  cmd, addr;
  logic [11:0] data, dac_a, dac_b;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic       busy_mid;
  logic [2:0] fv_seq, fe_seq;
  logic       busy_bad;
  logic [39:0] w;

  dac_spi_monitor_if bus ();

  dac_spi_monitor #(.SYNC_STAGES(2), .DATA_W(12)) dut (
    .qzt_clk(clk), .rst_n(rst_n), .spi(bus),
    .frame_valid(fv), .frame_error(fe), .cmd(cmd), .addr(addr), .data(data),
    .dac_a(dac_a), .dac_b(dac_b), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (fv) fv_cnt++;
    if (fe) fe_cnt++;
    if (fv && fe) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bits [from,to) of an n-bit word, MSB first; MOSI changes while SCK is low.
  task automatic send_bits(input logic [39:0] wd, input int n, input int from, input int to);
    for (int i = from; i < to; i++) begin
      bus.SPI_MOSI = wd[n-1-i];
      bus.SPI_SCK  = 1'b0;
      wait_neg(4);
      bus.SPI_SCK  = 1'b1;
      wait_neg(4);
      if (i == 15) busy_mid = busy;
    end
    bus.SPI_SCK = 1'b0;
    wait_neg(4);
  endtask

  task automatic cs_low();
    bus.DAC_CS = 1'b0;
    wait_neg(4);
  endtask

  // Pulse expected on the 4th negedge after CS is driven high (2 sync + DONE + register).
  task automatic end_frame();
    bus.DAC_CS = 1'b1;
    wait_neg(3);
    fv_seq[2] = fv; fe_seq[2] = fe;
    wait_neg(1);
    fv_seq[1] = fv; fe_seq[1] = fe;
    wait_neg(1);
    fv_seq[0] = fv; fe_seq[0] = fe;
    wait_neg(4);
  endtask

  function automatic logic [39:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
    return {8'h00, 8'hA5, c, a, d, 4'h9};
  endfunction

  task automatic frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
    cs_low();
    send_bits(mk(c, a, d), 32, 0, 32);
    end_frame();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.SPI_SCK = 1'b0; bus.SPI_MOSI = 1'b0; bus.DAC_CS = 1'b1; bus.DAC_CLR = 1'b1;
    busy_mid = 1'b0;
    wait_neg(3);
    chk("rst_fv", {31'd0, fv}, 32'd0);
    chk("rst_fe", {31'd0, fe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_addr_data", {12'd0, cmd, addr, data}, 32'd0);
    chk("rst_dac", {8'd0, dac_a, dac_b}, 32'd0);
    rst_n = 1'b1;
    wait_neg(6);

    // 1: write+update channel A
    frame(4'h3, 4'h0, 12'hABC);
    chk("t1_fv_seq", {29'd0, fv_seq}, 32'b010);
    chk("t1_fe_seq", {29'd0, fe_seq}, 32'b000);
    chk("t1_busy_mid", {31'd0, busy_mid}, 32'd1);
    chk("t1_cmd", {28'd0, cmd}, 32'h3);
    chk("t1_addr", {28'd0, addr}, 32'h0);
    chk("t1_data", {20'd0, data}, 32'hABC);
    chk("t1_dac_a", {20'd0, dac_a}, 32'hABC);
    chk("t1_dac_b", {20'd0, dac_b}, 32'h000);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: write+update both channels, exact latency
    frame(4'h3, 4'hF, 12'h123);
    chk("t2_fv_seq", {29'd0, fv_seq}, 32'b010);
    chk("t2_dac_a", {20'd0, dac_a}, 32'h123);
    chk("t2_dac_b", {20'd0, dac_b}, 32'h123);

    // 3: plain write, shadows untouched
    frame(4'h0, 4'h1, 12'h555);
    chk("t3_fv_seq", {29'd0, fv_seq}, 32'b010);
    chk("t3_cmd_addr_data", {12'd0, cmd, addr, data}, 32'h00_01555);
    chk("t3_dac_b", {20'd0, dac_b}, 32'h123);
    chk("t3_dac_a", {20'd0, dac_a}, 32'h123);

    // 4: 31-bit then 33-bit frames
    w = mk(4'h3, 4'hF, 12'h777);
    cs_low();
    send_bits(w, 31, 0, 31);
    end_frame();
    chk("t4a_fe_seq", {29'd0, fe_seq}, 32'b010);
    chk("t4a_fv_seq", {29'd0, fv_seq}, 32'b000);
    chk("t4a_data", {20'd0, data}, 32'h555);
    chk("t4a_dac_a", {20'd0, dac_a}, 32'h123);
    w = {7'd0, 1'b1, mk(4'h3, 4'hF, 12'h777)};
    cs_low();
    send_bits(w, 33, 0, 33);
    end_frame();
    chk("t4b_fe_seq", {29'd0, fe_seq}, 32'b010);
    chk("t4b_fv_seq", {29'd0, fv_seq}, 32'b000);
    chk("t4b_cmd", {28'd0, cmd}, 32'h0);
    chk("t4b_dac_b", {20'd0, dac_b}, 32'h123);
    chk("t4_fv_cnt", fv_cnt, 32'd3);
    chk("t4_fe_cnt", fe_cnt, 32'd2);

    // 5: reset after bit 10, tail of the frame must be ignored
    w = mk(4'h3, 4'h0, 12'hEEE);
    cs_low();
    send_bits(w, 32, 0, 10);
    rst_n = 1'b0;
    wait_neg(2);
    chk("t5_rst_dac_a", {20'd0, dac_a}, 32'h000);
    rst_n = 1'b1;
    wait_neg(2);
    send_bits(w, 32, 10, 32);
    end_frame();
    chk("t5_tail_busy", {31'd0, busy_mid}, 32'd0);
    chk("t5_tail_fv_seq", {29'd0, fv_seq}, 32'b000);
    chk("t5_tail_fe_seq", {29'd0, fe_seq}, 32'b000);
    frame(4'h3, 4'h1, 12'h0FF);
    chk("t5_fv_seq", {29'd0, fv_seq}, 32'b010);
    chk("t5_dac_b", {20'd0, dac_b}, 32'h0FF);
    chk("t5_dac_a", {20'd0, dac_a}, 32'h000);

    // 6: DAC_CLR mid-frame, then SCK traffic with CS high
    frame(4'h3, 4'h0, 12'hABC);
    chk("t6_pre_dac_a", {20'd0, dac_a}, 32'hABC);
    w = mk(4'h3, 4'hF, 12'h456);
    cs_low();
    send_bits(w, 32, 0, 12);
    bus.DAC_CLR = 1'b0;
    wait_neg(4);
    chk("t6_clr_dac_a", {20'd0, dac_a}, 32'h000);
    chk("t6_clr_dac_b", {20'd0, dac_b}, 32'h000);
    chk("t6_clr_busy", {31'd0, busy}, 32'd0);
    bus.DAC_CLR = 1'b1;
    wait_neg(4);
    send_bits(w, 32, 12, 32);
    end_frame();
    chk("t6_busy_mid", {31'd0, busy_mid}, 32'd0);
    chk("t6_fv_seq", {29'd0, fv_seq}, 32'b000);
    chk("t6_fe_seq", {29'd0, fe_seq}, 32'b000);
    busy_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.SPI_MOSI = i[0];
      bus.SPI_SCK  = 1'b1;
      wait_neg(4);
      if (busy) busy_bad = 1'b1;
      bus.SPI_SCK  = 1'b0;
      wait_neg(4);
      if (busy) busy_bad = 1'b1;
    end
    wait_neg(4);
    chk("t6_cs_high_busy", {31'd0, busy_bad}, 32'd0);
    chk("t6_fv_cnt", fv_cnt, 32'd5);
    chk("t6_fe_cnt", fe_cnt, 32'd2);
    frame(4'h2, 4'h1, 12'h321);
    chk("t6_rec_fv_seq", {29'd0, fv_seq}, 32'b010);
    chk("t6_rec_dac_b", {20'd0, dac_b}, 32'h321);
    chk("t6_rec_dac_a", {20'd0, dac_a}, 32'h000);
    chk("both_pulses", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
